dtree_feature_loader: RTL and testbench
=======================================

// Module: dtree_feature_loader
// PURPOSE
//  Front-end feeding the combinational decision-tree classifier. Assembles a byte stream
//  (valid/ready) into the parallel feature vector and holds it stable during evaluation.
//  Captures the classifier's class output and returns it downstream on a valid/ready port.
//  One frame in flight: load N_FEAT bytes -> evaluate -> deliver class -> next frame.
// PARAMETERS
//  N_FEAT      5    features per frame (bytes per frame)
//  FEAT_W      8    feature width; equals in_data width
//  CLASS_W     5    class index width
//  EVAL_CYCLES 1    cycles the vector is held before class_in is sampled (>=1)
//  TIMEOUT     255  idle-cycle limit inside a partial frame (used only with the macro)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  in_data    in   FEAT_W          feature byte; frame order = feature 0 first
//  in_valid   in   1               in_data valid
//  in_ready   out  1               loader accepts in_data (LOAD state only)
//  feat_vec   out  N_FEAT*FEAT_W   feature i at [i*FEAT_W +: FEAT_W]; to classifier
//  feat_valid out  1               feat_vec complete and stable (EVAL, RESULT)
//  class_in   in   CLASS_W         classifier output (combinational from feat_vec)
//  out_class  out  CLASS_W         registered class of the current frame
//  out_valid  out  1               out_class valid; held until out_ready
//  out_ready  in   1               downstream accepts out_class
//  frame_err  out  1               1-cycle pulse: partial frame discarded on timeout
// BEHAVIOUR
//  - Reset (async): state=LOAD, byte cnt=0, feat_vec=0, out_class=0, out_valid=0,
//    feat_valid=0, frame_err=0; in_ready=1 in LOAD, including immediately out of reset.
//  - All outputs are registered or decoded only from registered state; no in->out comb path.
//  - LOAD: byte accepted when in_valid&in_ready; written to slot cnt, cnt++. Acceptance of
//    byte N_FEAT-1 -> EVAL next cycle, cnt=0. Slots not yet written this frame keep old data.
//  - EVAL: in_ready=0, feat_valid=1, counter runs EVAL_CYCLES cycles; on the last, class_in
//    is registered into out_class -> RESULT.
//  - RESULT: out_valid=1, feat_valid=1, in_ready=0. out_ready=1 -> LOAD, out_valid=0.
//    out_class keeps its value until the next capture.
//  - Latency: last byte accepted at cycle t -> out_valid=1 at t+1+EVAL_CYCLES.
//  - out_ready is ignored unless out_valid=1; in_valid is ignored outside LOAD.
//  - cnt wraps only via the LOAD->EVAL transition; it never exceeds N_FEAT-1.
//  - Reset mid-frame or mid-result: partial frame and pending class are dropped.
// CONFIGURATION
//  DTREE_LOADER_TIMEOUT_EN defined: in LOAD with cnt>0, an idle counter increments each
//    cycle without an accepted byte and clears on acceptance. On reaching TIMEOUT:
//    cnt=0, frame_err=1 for one cycle, and the next byte is feature 0.
//  Undefined: no idle counter is built, frame_err is tied 0, partial frames wait forever.
// STRUCTURE
//  Package dtree_pkg: N_FEAT, FEAT_W, CLASS_W constants, class_t typedef,
//    loader state enum {LOAD, EVAL, RESULT}.
//  Sub-module dtree_feat_sipo: byte-indexed write into the feature register bank
//    (write enable + slot index in; feat_vec out). FSM, counters and timeout stay in top.
// TESTING
//  1. Reset; bytes 10,20,30,40,50 (hex) back-to-back; class_in=7 ->
//     feat_vec=0x5040302010, feat_valid the cycle after byte 4,
//     out_valid at t+2 (EVAL_CYCLES=1), out_class=7.
//  2. Hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid stays 1, in_ready=0,
//     no byte consumed. Raise out_ready -> LOAD; next 5 bytes form a new vector.
//  3. Random 0-20 cycle in_valid gaps (macro off) -> identical feat_vec and class as test 1.
//  4. Macro on, TIMEOUT=8: send 2 bytes, idle 8 cycles -> frame_err pulse, cnt=0;
//     bytes AA..EE then yield feat_vec=0xEEDDCCBBAA. Macro off: idle 100 cycles,
//     3 more bytes complete the frame, frame_err stays 0.
//  5. Assert rst after 3 bytes, and again while in RESULT -> all outputs 0 asynchronously,
//     in_ready=1 after release, next byte lands in feature 0.
//  6. class_in=31 (max), EVAL_CYCLES=3 -> out_class=31, sampled exactly 3 cycles after the
//     last byte; a class_in change during cycles 1-2 does not affect out_class.

Source files
------------

// File: rtl/dtree_pkg.sv
// Shared constants and types for the decision-tree feature loader.
package dtree_pkg;

  localparam int unsigned N_FEAT  = 5;
  localparam int unsigned FEAT_W  = 8;
  localparam int unsigned CLASS_W = 5;
  localparam int unsigned CNT_W   = $clog2(N_FEAT);

  typedef logic [CLASS_W-1:0] class_t;

  typedef enum logic [1:0] {
    LOAD,
    EVAL,
    RESULT
  } loader_state_t;

endpackage

// File: rtl/dtree_feat_sipo.sv
// Feature register bank: one byte written per enable into the indexed slot.
module dtree_feat_sipo
  import dtree_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_idx,
  input  logic [FEAT_W-1:0]        wr_data,
  output logic [N_FEAT*FEAT_W-1:0] feat_vec
);

  // NOTE: this bank is plain flops, not RAM, so it takes the async reset; the
  // classifier must see an all-zero vector out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_vec <= '0;
    end else if (wr_en) begin
      feat_vec[wr_idx*FEAT_W +: FEAT_W] <= wr_data;
    end
  end

endmodule

// File: rtl/dtree_feature_loader.sv
// Byte-stream to feature-vector loader with class capture for the decision tree.
// Optional idle timeout on partial frames: define DTREE_LOADER_TIMEOUT_EN.
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int unsigned EVAL_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FEAT_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_FEAT*FEAT_W-1:0] feat_vec,
  output logic                     feat_valid,
  input  logic [CLASS_W-1:0]       class_in,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err
);

  localparam int unsigned      EC_W      = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [EC_W-1:0]  EVAL_LAST = EC_W'(EVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_FEAT - 1);

  loader_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [EC_W-1:0]  eval_cnt;
  logic             accept, last_byte, eval_done, flush;

  assign accept    = in_valid & in_ready;
  assign last_byte = accept && (cnt == CNT_LAST);
  assign eval_done = (state == EVAL) && (eval_cnt == EVAL_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      LOAD:    if (last_byte) state_nxt = EVAL;
      EVAL:    if (eval_done) state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    feat_valid = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      LOAD:   in_ready = 1'b1;
      EVAL:   feat_valid = 1'b1;
      RESULT: begin
        feat_valid = 1'b1;
        out_valid  = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte counter returns to 0 only on frame completion or a timeout flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (last_byte || flush) cnt <= '0;
    else if (accept)             cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 eval_cnt <= '0;
    else if (state != EVAL)  eval_cnt <= '0;
    else                     eval_cnt <= eval_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            out_class <= '0;
    else if (eval_done) out_class <= class_in;
  end

`ifdef DTREE_LOADER_TIMEOUT_EN
  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the edge where the idle count would reach TIMEOUT.
  assign flush = (state == LOAD) && (cnt != '0) && !accept && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= flush;
      if (state != LOAD || cnt == '0 || accept || flush) idle_cnt <= '0;
      else                                               idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign flush     = 1'b0;
  assign frame_err = 1'b0;
`endif

  dtree_feat_sipo u_sipo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_idx   (cnt),
    .wr_data  (in_data),
    .feat_vec (feat_vec)
  );

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader: one instance with EVAL_CYCLES=1, one with 3.
module tb_dtree_feature_loader;
  import dtree_pkg::*;

  localparam int unsigned VW = N_FEAT * FEAT_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [FEAT_W-1:0]  in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_valid3 = 1'b0;
  logic               out_ready = 1'b0;
  logic               out_ready3 = 1'b0;
  logic [CLASS_W-1:0] class_in = '0;

  logic               in_ready, feat_valid, out_valid, frame_err;
  logic [VW-1:0]      feat_vec;
  logic [CLASS_W-1:0] out_class;
  logic               in_ready3, feat_valid3, out_valid3, frame_err3;
  logic [VW-1:0]      feat_vec3;
  logic [CLASS_W-1:0] out_class3;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  dtree_feature_loader #(.EVAL_CYCLES(1), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .feat_vec(feat_vec), .feat_valid(feat_valid), .class_in(class_in),
    .out_class(out_class), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err)
  );

  dtree_feature_loader #(.EVAL_CYCLES(3), .TIMEOUT(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid3), .in_ready(in_ready3),
    .feat_vec(feat_vec3), .feat_valid(feat_valid3), .class_in(class_in),
    .out_class(out_class3), .out_valid(out_valid3), .out_ready(out_ready3),
    .frame_err(frame_err3)
  );

  always @(negedge clk) if (frame_err) err_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [FEAT_W-1:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    tick();
  endtask

  task automatic send_range(input logic [FEAT_W-1:0] b [N_FEAT], input int lo, input int hi,
                            input int max_gap);
    int gap;
    for (int i = lo; i <= hi; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      send_byte(b[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FEAT_W-1:0] fr [N_FEAT];
    int lat, base;
    logic stall_ok;

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_feat_valid", feat_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_feat_vec", feat_vec, '0);
    check("rst_out_class", out_class, '0);
    check("rst_frame_err", frame_err, 1'b0);
    tick();
    rst = 1'b0;

    // 1: back-to-back frame
    fr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    class_in = 5'd7;
    send_range(fr, 0, 4, 0);
    check("t1_feat_valid", feat_valid, 1'b1);
    check("t1_feat_vec", feat_vec, 64'h50_4030_2010);
    check("t1_in_ready_eval", in_ready, 1'b0);
    check("t1_out_valid_eval", out_valid, 1'b0);
    wait_out(lat);
    check("t1_latency", lat, 1);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_class", out_class, 5'd7);

    // 2: downstream backpressure holds result and blocks input
    in_valid = 1'b1;
    in_data  = 8'h99;
    stall_ok = 1'b1;
    repeat (10) begin
      tick();
      if (!out_valid || in_ready) stall_ok = 1'b0;
    end
    check("t2_stall_hold", stall_ok, 1'b1);
    check("t2_class_held", out_class, 5'd7);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t2_out_valid_clr", out_valid, 1'b0);
    check("t2_in_ready", in_ready, 1'b1);
    check("t2_feat_valid_clr", feat_valid, 1'b0);
    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    class_in = 5'd3;
    send_range(fr, 0, 4, 0);
    check("t2_feat_vec", feat_vec, 64'h05_0403_0201);
    wait_out(lat);
    check("t2_out_class", out_class, 5'd3);
    deliver();

    // 3: random gaps, and unwritten slots keep previous frame data
    fr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    class_in = 5'd7;
    send_range(fr, 0, 1, 20);
    check("t3_partial_vec", feat_vec, 64'h05_0403_2010);
    send_range(fr, 2, 4, 20);
    check("t3_feat_vec", feat_vec, 64'h50_4030_2010);
    wait_out(lat);
    check("t3_latency", lat, 1);
    check("t3_out_class", out_class, 5'd7);
    deliver();

    // 4: partial-frame idle behaviour
    base = err_pulses;
`ifdef DTREE_LOADER_TIMEOUT_EN
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_range(fr, 0, 1, 0);
    repeat (12) tick();
    check("t4_err_pulses", err_pulses - base, 1);
    check("t4_in_ready", in_ready, 1'b1);
    fr = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    class_in = 5'h15;
    send_range(fr, 0, 4, 0);
    check("t4_feat_vec", feat_vec, 64'hEE_DDCC_BBAA);
    wait_out(lat);
    check("t4_out_class", out_class, 5'h15);
    deliver();
`else
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    class_in = 5'h12;
    send_range(fr, 0, 2, 0);
    repeat (100) tick();
    check("t4_still_loading", in_ready, 1'b1);
    check("t4_no_feat_valid", feat_valid, 1'b0);
    send_range(fr, 3, 4, 0);
    check("t4_feat_vec", feat_vec, 64'h55_4433_2211);
    check("t4_err_pulses", err_pulses - base, 0);
    wait_out(lat);
    check("t4_out_class", out_class, 5'h12);
    deliver();
`endif

    // 5: reset mid-frame and mid-result
    fr = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    send_range(fr, 0, 2, 0);
    #2 rst = 1'b1;
    #1;
    check("t5a_in_ready", in_ready, 1'b1);
    check("t5a_feat_vec", feat_vec, '0);
    check("t5a_out_class", out_class, '0);
    check("t5a_feat_valid", feat_valid, 1'b0);
    tick();
    rst = 1'b0;
    fr = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    class_in = 5'h0A;
    send_range(fr, 0, 0, 0);
    check("t5_first_slot", feat_vec, 64'h77);
    send_range(fr, 1, 4, 0);
    wait_out(lat);
    check("t5b_out_valid", out_valid, 1'b1);
    check("t5b_out_class", out_class, 5'h0A);
    #2 rst = 1'b1;
    #1;
    check("t5b_out_valid_rst", out_valid, 1'b0);
    check("t5b_out_class_rst", out_class, '0);
    check("t5b_feat_valid_rst", feat_valid, 1'b0);
    check("t5b_feat_vec_rst", feat_vec, '0);
    tick();
    rst = 1'b0;
    check("t5b_in_ready", in_ready, 1'b1);

    // 6: EVAL_CYCLES=3 instance samples class_in only in the third eval cycle
    in_valid3 = 1'b1;
    for (int i = 0; i < int'(N_FEAT); i++) begin
      in_data = FEAT_W'(i + 1);
      check("t6_in_ready3", in_ready3, 1'b1);
      tick();
    end
    in_valid3 = 1'b0;
    class_in = 5'd4;
    check("t6_c1_out_valid", out_valid3, 1'b0);
    check("t6_c1_feat_valid", feat_valid3, 1'b1);
    tick();
    class_in = 5'd9;
    check("t6_c2_out_valid", out_valid3, 1'b0);
    tick();
    class_in = 5'd31;
    check("t6_c3_out_valid", out_valid3, 1'b0);
    tick();
    check("t6_out_valid", out_valid3, 1'b1);
    check("t6_out_class", out_class3, 5'd31);
    check("t6_feat_vec", feat_vec3, 64'h05_0403_0201);
    class_in = 5'd0;
    tick();
    check("t6_class_held", out_class3, 5'd31);
    check("t6_frame_err3", frame_err3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
